// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

    // Clear-engine FSM states.
    typedef enum logic [0:0] {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

    localparam int unsigned RF_WIDTH = 32;
    localparam int unsigned RF_DEPTH = 32;

    // Address width needed to index a register array of the given depth.
    function automatic int unsigned rf_addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_multi_if.sv
// Register file access bundle: two read ports, one write port, clear request
// and busy status. The master drives addresses/data, the slave returns data.
interface regfile_multi_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = RF_WIDTH,
    parameter int unsigned DEPTH = RF_DEPTH
);
    localparam int unsigned AW = rf_addr_width(DEPTH);

    logic [AW-1:0]    ra0;
    logic [WIDTH-1:0] rd0;
    logic [AW-1:0]    ra1;
    logic [WIDTH-1:0] rd1;
    logic [AW-1:0]    wa;
    logic             we;
    logic [WIDTH-1:0] wd;
    logic             clr_req;
    logic             busy;

    modport master (
        output ra0, ra1, wa, we, wd, clr_req,
        input  rd0, rd1, busy
    );

    modport slave (
        input  ra0, ra1, wa, we, wd, clr_req,
        output rd0, rd1, busy
    );

endinterface

// File: rtl/regfile_clear_ctrl.sv
// Sequential clear engine: sweeps every register to zero after reset or on
// request, one register per clock edge, and flags busy while doing so.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = RF_DEPTH,
    localparam int unsigned AW   = rf_addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    rf_state_t     state_q;
    logic [AW-1:0] clr_cnt_q;
    logic          busy_q;

    // FSM, sweep counter and registered busy flag; reset restarts the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                RF_IDLE: begin
                    if (clr_req) begin
                        state_q   <= RF_CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    // clr_req is ignored mid-sweep.
                    if (clr_cnt_q == LastAddr) begin
                        state_q   <= RF_IDLE;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= RF_CLEAR;
                    clr_cnt_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign clr_we   = busy_q;
    assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/regfile_multi.sv
// DEPTH x WIDTH register file: two combinational read ports, one synchronous
// write port, optional hard-wired zero register and a built-in clear sweep.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read
// forwarding while idle.
module regfile_multi
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = RF_WIDTH,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_multi_if.slave bus
);

    localparam int unsigned AW = rf_addr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             busy;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             usr_wr_ok;

    logic [WIDTH-1:0] rd0_val;
    logic [WIDTH-1:0] rd1_val;

    regfile_clear_ctrl #(
        .DEPTH (DEPTH)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (bus.clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A user write is legal only when idle and not aimed at the zero register.
    assign usr_wr_ok = bus.we && !((ZERO_REG != 0) && (bus.wa == '0));

    // Write mux: the clear sweep owns the write port and user writes are dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.wa;
        wr_data = bus.wd;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (usr_wr_ok) begin
            wr_en = 1'b1;
        end
    end

    // Register array; deliberately unreset, the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read muxes: bypass (if built), then zero register, then the busy blank.
    always_comb begin
        rd0_val = mem[bus.ra0];
        rd1_val = mem[bus.ra1];
`ifdef REGFILE_BYPASS_EN
        if (bus.we && (bus.ra0 == bus.wa)) begin
            rd0_val = bus.wd;
        end
        if (bus.we && (bus.ra1 == bus.wa)) begin
            rd1_val = bus.wd;
        end
`endif
        if ((ZERO_REG != 0) && (bus.ra0 == '0)) begin
            rd0_val = '0;
        end
        if ((ZERO_REG != 0) && (bus.ra1 == '0)) begin
            rd1_val = '0;
        end
        if (busy) begin
            rd0_val = '0;
            rd1_val = '0;
        end
    end

    assign bus.rd0  = rd0_val;
    assign bus.rd1  = rd1_val;
    assign bus.busy = busy;

endmodule

// File: tb/tb_regfile_multi.sv
// Self-checking bench for regfile_multi (32x32, zero register enabled).
// Honours REGFILE_BYPASS_EN when the design is built with it.
module tb_regfile_multi;

    localparam int unsigned W = 32;
    localparam int unsigned D = 32;

    logic clk;
    logic rst_n;

    regfile_multi_if #(.WIDTH(W), .DEPTH(D)) bus ();

    regfile_multi #(
        .WIDTH    (W),
        .DEPTH    (D),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [W-1:0] model [D];
    logic [W-1:0] exp_q [$];

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_rd(input int unsigned a);
        return (a == 0) ? '0 : model[a];
    endfunction

    task automatic model_zero();
        for (int i = 0; i < int'(D); i++) model[i] = '0;
    endtask

    // Set both read addresses, queue expected data, then compare what comes back.
    task automatic rd_check(input string tag, input int unsigned a0, input int unsigned a1);
        bus.ra0 = 5'(a0);
        bus.ra1 = 5'(a1);
        exp_q.push_back(model_rd(a0));
        exp_q.push_back(model_rd(a1));
        #1;
        check({tag, "_rd0"}, bus.rd0, exp_q.pop_front());
        check({tag, "_rd1"}, bus.rd1, exp_q.pop_front());
    endtask

    task automatic do_write(input int unsigned a, input logic [W-1:0] d);
        @(negedge clk);
        bus.we = 1'b1;
        bus.wa = 5'(a);
        bus.wd = d;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    // Count edges until busy drops, bounded so a stuck busy cannot hang the run.
    task automatic count_busy(output int unsigned n);
        n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < int'(D); i++) rd_check(tag, i, D - 1 - i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        int unsigned hi;
        int unsigned a;
        logic [W-1:0] d;

        rst_n       = 1'b0;
        bus.we      = 1'b0;
        bus.wa      = '0;
        bus.wd      = '0;
        bus.ra0     = 5'd3;
        bus.ra1     = 5'd17;
        bus.clr_req = 1'b0;
        for (int i = 0; i < int'(D); i++) model[i] = 'x;

        // Power-up reset and sweep length.
        #12;
        check("rst_busy", {31'd0, bus.busy}, 32'd1);
        check("rst_rd0", bus.rd0, '0);
        check("rst_rd1", bus.rd1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        check("por_busy_edges", n, 32'd32);
        model_zero();
        read_all("por");

        // Write 0xDEADBEEF to 5; pre-edge value depends on bypass.
        @(negedge clk);
        bus.we  = 1'b1;
        bus.wa  = 5'd5;
        bus.wd  = 32'hDEADBEEF;
        bus.ra0 = 5'd5;
        bus.ra1 = 5'd5;
        exp_q.push_back(Bypass ? 32'hDEADBEEF : 32'h0);
        #1;
        check("pre_edge_rd0_5", bus.rd0, exp_q.pop_front());
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
        model[5] = 32'hDEADBEEF;
        rd_check("wr5", 5, 5);

        // Forwarding on wa=7 against an older value; other port unaffected.
        do_write(7, 32'h00000077);
        @(negedge clk);
        bus.we  = 1'b1;
        bus.wa  = 5'd7;
        bus.wd  = 32'hA5A5A5A5;
        bus.ra0 = 5'd7;
        bus.ra1 = 5'd5;
        exp_q.push_back(Bypass ? 32'hA5A5A5A5 : 32'h00000077);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        check("bypass_rd0_7", bus.rd0, exp_q.pop_front());
        check("bypass_rd1_5", bus.rd1, exp_q.pop_front());
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
        model[7] = 32'hA5A5A5A5;
        rd_check("wr7", 7, 5);

        // Zero register: write discarded and never forwarded.
        @(negedge clk);
        bus.we  = 1'b1;
        bus.wa  = 5'd0;
        bus.wd  = 32'h12345678;
        bus.ra0 = 5'd0;
        bus.ra1 = 5'd0;
        #1;
        check("zero_pre_edge", bus.rd0, '0);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        rd_check("zero_post", 0, 7);

        // Assorted writes read back on both ports.
        for (int k = 0; k < 8; k++) begin
            a = $urandom_range(1, D - 1);
            d = $urandom;
            do_write(a, d);
            rd_check("rand", a, $urandom_range(0, D - 1));
        end

        // Clear request together with a write; mid-sweep clr_req and writes ignored.
        do_write(3, 32'h11);
        rd_check("wr3", 3, 7);
        @(negedge clk);
        bus.clr_req = 1'b1;
        bus.we      = 1'b1;
        bus.wa      = 5'd4;
        bus.wd      = 32'h22;
        @(posedge clk);
        #1;
        bus.clr_req = 1'b0;
        bus.we      = 1'b0;
        check("clr_busy_rise", {31'd0, bus.busy}, 32'd1);
        bus.ra0 = 5'd3;
        bus.ra1 = 5'd7;
        #1;
        check("clr_blank_rd0", bus.rd0, '0);
        check("clr_blank_rd1", bus.rd1, '0);
        hi = 0;
        for (int e = 1; e <= 31; e++) begin
            @(negedge clk);
            bus.clr_req = (e == 10);
            if (e == 31) begin
                bus.we = 1'b1;
                bus.wa = 5'd1;
                bus.wd = 32'h99;
            end
            @(posedge clk);
            #1;
            if (bus.busy) hi++;
        end
        bus.clr_req = 1'b0;
        check("clr_busy_edges", hi, 32'd31);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        check("clr_busy_fall", {31'd0, bus.busy}, 32'd0);
        model_zero();
        rd_check("clr_r34", 3, 4);
        rd_check("clr_drop1", 1, 7);
        read_all("clr");
        do_write(9, 32'h9999);
        rd_check("first_wr", 9, 9);

        // Reset part-way through a sweep over a fully populated array.
        for (int i = 1; i < int'(D); i++) do_write(i, 32'h01010101 * i);
        rd_check("fill", 20, 31);
        @(negedge clk);
        bus.clr_req = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_req = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b0;
        bus.ra0 = 5'd20;
        bus.ra1 = 5'd31;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd1);
        check("midrst_rd0", bus.rd0, '0);
        check("midrst_rd1", bus.rd1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        check("midrst_busy_edges", n, 32'd32);
        model_zero();
        read_all("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
